// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the program-ROM port arbiter.
// The ROM geometry constants match rom_program.
package rom_arb_pkg;

    localparam int ROM_ADDR_W = 10;
    localparam int ROM_DATA_W = 32;
    localparam int STARVE_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_LS   = 2'b10
    } own_t;

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// Saturating count of LS wins taken while IF was waiting.
// at_max tells the arbiter to hand the next conflict to IF.
module rom_arb_starve_cnt
    import rom_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                clr,
    input  logic [STARVE_W-1:0] max_val,
    output logic                at_max
);

    logic [STARVE_W-1:0] cnt_q;

    // Clear takes precedence; the two are mutually exclusive in practice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != max_val)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_max = (cnt_q == max_val);

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single-port program ROM between instruction fetch (IF) and
// load/store (LS): LS has priority, IF is guaranteed a win after STARVE_MAX losses.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int DATA_W     = ROM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

    // Handshake: a requester holds req and addr stable until it sees gnt in the
    // same cycle; the read it started returns exactly one cycle later as a
    // single-cycle rvalid strobe with rdata, with no back-pressure on the return.
    logic if_win;
    logic ls_win;
    logic at_max;
    own_t own_q;

    assign ls_win = rst_n & ls_req_i & ~(if_req_i & at_max);
    assign if_win = rst_n & if_req_i & (~ls_req_i | at_max);

    assign if_gnt_o = if_win;
    assign ls_gnt_o = ls_win;
    assign rom_ce_o = if_win | ls_win;

    always_comb begin
        rom_addr_o = '0;
        if (if_win) begin
            rom_addr_o = if_addr_i;
        end else if (ls_win) begin
            rom_addr_o = ls_addr_i;
        end
    end

    rom_arb_starve_cnt u_starve_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (ls_win & if_req_i),
        .clr     (if_win),
        .max_val (STARVE_MAX_C),
        .at_max  (at_max)
    );

    // Owner of the read in flight; async reset drops any pending return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q <= OWN_NONE;
        end else if (if_win) begin
            own_q <= OWN_IF;
        end else if (ls_win) begin
            own_q <= OWN_LS;
        end else begin
            own_q <= OWN_NONE;
        end
    end

    assign if_rvalid_o = rst_n & (own_q == OWN_IF);
    assign ls_rvalid_o = rst_n & (own_q == OWN_LS);
    assign if_rdata_o  = if_rvalid_o ? rom_data_i : '0;
    assign ls_rdata_o  = ls_rvalid_o ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a one-cycle-latency ROM model
// (word[k] = 32'hA500_0000 | k).
module tb_rom_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam logic [DW-1:0] ROM_TAG = 32'hA500_0000;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic [AW-1:0] ls_addr;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    int n_assert;
    int n_fail;

    rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .ls_req_i    (ls_req),
        .ls_addr_i   (ls_addr),
        .ls_gnt_o    (ls_gnt),
        .ls_rvalid_o (ls_rvalid),
        .ls_rdata_o  (ls_rdata),
        .rom_ce_o    (rom_ce),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data)
    );

    // clock and ROM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_ce) rom_data <= ROM_TAG | {22'b0, rom_addr};
    end

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return ROM_TAG | {22'b0, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ce"}, {31'b0, rom_ce}, 0);
        chk({tag, "_addr"}, {22'b0, rom_addr}, 0);
        chk({tag, "_if_gnt"}, {31'b0, if_gnt}, 0);
        chk({tag, "_ls_gnt"}, {31'b0, ls_gnt}, 0);
        chk({tag, "_if_rv"}, {31'b0, if_rvalid}, 0);
        chk({tag, "_ls_rv"}, {31'b0, ls_rvalid}, 0);
        chk({tag, "_if_rd"}, if_rdata, 0);
        chk({tag, "_ls_rd"}, ls_rdata, 0);
    endtask

    bit            exp_ls[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit            alt_ls[4]  = '{0, 1, 0, 1};
    logic [AW-1:0] la;
    logic [AW-1:0] ia;
    logic [AW-1:0] prev_addr;
    bit            prev_ls;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rom_data = '0;
        // reset with requests asserted: everything must stay quiet
        rst_n = 1'b0; if_req = 1'b1; if_addr = 10'd7; ls_req = 1'b1; ls_addr = 10'd8;
        tick();
        chk_quiet("reset");
        tick();
        if_req = 1'b0; ls_req = 1'b0;
        rst_n = 1'b1;

        // IF only, first cycle out of reset
        if_req = 1'b1; if_addr = 10'd3;
        #1;
        chk("t1_if_gnt", {31'b0, if_gnt}, 1);
        chk("t1_ce", {31'b0, rom_ce}, 1);
        chk("t1_addr", {22'b0, rom_addr}, 3);
        tick();
        chk("t1_if_rv", {31'b0, if_rvalid}, 1);
        chk("t1_if_rd", if_rdata, word(10'd3));
        chk("t1_ls_rv", {31'b0, ls_rvalid}, 0);
        chk("t1_ls_rd", ls_rdata, 0);

        // conflict: LS wins, IF follows
        if_req = 1'b1; if_addr = 10'd1; ls_req = 1'b1; ls_addr = 10'd2;
        #1;
        chk("t2_ls_gnt", {31'b0, ls_gnt}, 1);
        chk("t2_if_gnt", {31'b0, if_gnt}, 0);
        chk("t2_addr", {22'b0, rom_addr}, 2);
        tick();
        ls_req = 1'b0;
        #1;
        chk("t2_ls_rv", {31'b0, ls_rvalid}, 1);
        chk("t2_ls_rd", ls_rdata, word(10'd2));
        chk("t2_if_gnt2", {31'b0, if_gnt}, 1);
        chk("t2_addr2", {22'b0, rom_addr}, 1);
        tick();
        if_req = 1'b0;
        #1;
        chk("t2_if_rv", {31'b0, if_rvalid}, 1);
        chk("t2_if_rd", if_rdata, word(10'd1));
        chk("t2_ls_rd0", ls_rdata, 0);
        chk("t2_ce_idle", {31'b0, rom_ce}, 0);
        tick();

        // continuous contention, starvation guard
        la = 10'd10; ia = 10'd30; prev_ls = 1'b0; prev_addr = '0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                chk($sformatf("t3_ls_rv%0d", i), {31'b0, ls_rvalid}, {31'b0, prev_ls});
                chk($sformatf("t3_if_rv%0d", i), {31'b0, if_rvalid}, {31'b0, !prev_ls});
                chk($sformatf("t3_rd%0d", i), prev_ls ? ls_rdata : if_rdata, word(prev_addr));
            end
            ls_req = 1'b1; ls_addr = la; if_req = 1'b1; if_addr = ia;
            #1;
            chk($sformatf("t3_ls_gnt%0d", i), {31'b0, ls_gnt}, {31'b0, exp_ls[i]});
            chk($sformatf("t3_if_gnt%0d", i), {31'b0, if_gnt}, {31'b0, !exp_ls[i]});
            chk($sformatf("t3_addr%0d", i), {22'b0, rom_addr}, {22'b0, exp_ls[i] ? la : ia});
            prev_ls   = exp_ls[i];
            prev_addr = exp_ls[i] ? la : ia;
            if (exp_ls[i]) la = la + 1'b1; else ia = ia + 1'b1;
            tick();
        end
        ls_req = 1'b0; if_req = 1'b0;
        chk("t3_last_rv", {31'b0, if_rvalid}, 1);
        chk("t3_last_rd", if_rdata, word(10'd31));
        tick();

        // alternating single requests, one return per cycle
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                chk($sformatf("t4_ls_rv%0d", i), {31'b0, ls_rvalid}, {31'b0, alt_ls[i-1]});
                chk($sformatf("t4_if_rv%0d", i), {31'b0, if_rvalid}, {31'b0, !alt_ls[i-1]});
                chk($sformatf("t4_rd%0d", i), alt_ls[i-1] ? ls_rdata : if_rdata,
                    word(10'(i + 4)));
                chk($sformatf("t4_other_rd%0d", i), alt_ls[i-1] ? if_rdata : ls_rdata, 0);
            end
            if (i < 4) begin
                ls_req = alt_ls[i]; if_req = !alt_ls[i];
                ls_addr = 10'(i + 5); if_addr = 10'(i + 5);
                #1;
                chk($sformatf("t4_ce%0d", i), {31'b0, rom_ce}, 1);
                chk($sformatf("t4_addr%0d", i), {22'b0, rom_addr}, 32'(i + 5));
            end else begin
                ls_req = 1'b0; if_req = 1'b0;
            end
            tick();
        end

        // build up starve count, then reset with an LS read in flight
        if_req = 1'b1; if_addr = 10'd50;
        for (int i = 0; i < 2; i++) begin
            ls_req = 1'b1; ls_addr = 10'(40 + i);
            #1;
            chk($sformatf("t5_pre_ls%0d", i), {31'b0, ls_gnt}, 1);
            tick();
        end
        ls_addr = 10'd9;
        #1;
        chk("t5_ls_gnt9", {31'b0, ls_gnt}, 1);
        chk("t5_addr9", {22'b0, rom_addr}, 9);
        rst_n = 1'b0;
        #1;
        chk_quiet("t5_rst_a");
        ls_req = 1'b0; if_req = 1'b0;
        tick();
        chk_quiet("t5_rst_b");
        tick();
        chk_quiet("t5_rst_c");
        rst_n = 1'b1;
        #1;
        chk_quiet("t5_rel");
        // cleared counter: four LS wins before IF
        if_req = 1'b1; if_addr = 10'd60;
        for (int i = 0; i < 5; i++) begin
            ls_req = 1'b1; ls_addr = 10'(70 + i);
            #1;
            chk($sformatf("t5_ls_gnt%0d", i), {31'b0, ls_gnt}, {31'b0, i < 4});
            chk($sformatf("t5_if_gnt%0d", i), {31'b0, if_gnt}, {31'b0, i == 4});
            tick();
        end
        ls_req = 1'b0; if_req = 1'b0;
        tick();

        // idle
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_quiet($sformatf("t6_idle%0d", i));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
